decod_line_encoder: RTL

- Sequential 16-line request encoder; the inverse of the team's 4-to-16 line decoder.
- Collects requests on 16 one-hot/multi-hot lines and serves them one at a time.
- Each serve is emitted as a 4-bit code plus enable in the decoder's own input format, so feeding the outputs straight into the decoder re-asserts the requesting line.
- Sits between request sources and the decoder; valid/ready handshake toward the consumer.

---
 rtl/decod_line_encoder.sv | 99 +++++++++
 1 files changed

// File: rtl/decod_line_encoder.sv
// Sequential 16-line request encoder: collects multi-hot requests and serves them one
// at a time as {code, en} in the 4-to-16 line decoder's input format (code = ~index).
module decod_line_encoder #(
    parameter logic RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [3:0]  code,
    output logic        en,
    output logic [15:0] pend,
    output logic [4:0]  pend_cnt
);

    logic [15:0] pend_q, pend_d;
    logic        valid_q, valid_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [4:0]  cnt_q, cnt_d;

    logic        acc;
    logic [15:0] served;
    logic [15:0] cand;
    logic [3:0]  base;
    logic [3:0]  sel_idx;
    logic        sel_found;

    // NOTE: every variable gets a default at the top of the block so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        acc    = valid_q & out_ready;
        served = acc ? (16'h0001 << idx_q) : 16'h0000;
        // Only registered pend is eligible: a request never wins in its arrival cycle.
        cand   = pend_q & ~served;
        base   = RR_EN ? ptr_q : 4'd0;

        // Scan from the far end back toward base so the first hit after base wins.
        sel_idx   = 4'd0;
        sel_found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (cand[base + 4'(i)]) begin
                sel_idx   = base + 4'(i);
                sel_found = 1'b1;
            end
        end

        pend_d  = flush ? 16'h0000 : (cand | req);
        valid_d = valid_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;

        // While holding (valid & ~ready) nothing re-arbitrates; idx holds when idle.
        if (flush) begin
            valid_d = 1'b0;
        end else if (!valid_q || acc) begin
            valid_d = sel_found;
            if (sel_found) begin
                idx_d = sel_idx;
            end
        end

        if (acc && !flush) begin
            ptr_d = idx_q + 4'd1;
        end

        cnt_d = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt_d = cnt_d + 5'(pend_d[i]);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= 16'h0000;
            valid_q <= 1'b0;
            idx_q   <= 4'd0;
            ptr_q   <= 4'd0;
            cnt_q   <= 5'd0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign en        = valid_q;
    assign code      = ~idx_q;
    assign pend      = pend_q;
    assign pend_cnt  = cnt_q;

endmodule
